// File: rtl/jtag_tap_slave.sv
// jtag_tap_slave: oversampled IEEE 1149.1 TAP with IR, BYPASS, IDCODE and USER data registers
module jtag_tap_slave #(
    parameter int          IR_WIDTH   = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001,
    parameter int          USER_WIDTH = 32,
    parameter int          USER_OP    = 2
) (
    input  logic                  bus_clk,
    input  logic                  bus_reset,
    input  logic                  tck_in,
    input  logic                  tms_in,
    input  logic                  tdi_in,
    output logic                  tdo_out,
    output logic                  tdo_oe,
    input  logic [USER_WIDTH-1:0] user_capture_data,
    output logic [USER_WIDTH-1:0] user_update_data,
    output logic                  user_update_strobe,
    output logic [3:0]            tap_state,
    output logic                  test_logic_reset
);
    typedef enum logic [3:0] {
        TLR    = 4'hF, RTI    = 4'hC, SEL_DR = 4'h7, CAP_DR = 4'h6,
        SH_DR  = 4'h2, EX1_DR = 4'h1, PAU_DR = 4'h3, EX2_DR = 4'h0,
        UPD_DR = 4'h5, SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR  = 4'hA,
        EX1_IR = 4'h9, PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
    } state_t;

    logic r_tck_m, r_tck_s, r_tck_d, r_tms_m, r_tms_s, r_tdi_m, r_tdi_s;
    state_t r_state, w_next;
    logic [IR_WIDTH-1:0]   r_ir, r_ir_sr;
    logic [31:0]           r_id_sr;
    logic [USER_WIDTH-1:0] r_user_sr, r_user_upd;
    logic                  r_byp, r_tdo, r_oe, r_strobe;
    logic w_rise, w_fall, w_sel_id, w_sel_user, w_dr_lsb;

    assign w_rise     = r_tck_s & ~r_tck_d;
    assign w_fall     = ~r_tck_s & r_tck_d;
    assign w_sel_id   = r_ir == IR_WIDTH'(1);
    assign w_sel_user = (r_ir == IR_WIDTH'(USER_OP)) && !w_sel_id;
    assign w_dr_lsb   = w_sel_id ? r_id_sr[0] : w_sel_user ? r_user_sr[0] : r_byp;

    // two-flop synchronisers plus a delayed tck for edge detection
    always_ff @(posedge bus_clk) begin
        if (bus_reset) begin
            {r_tck_m, r_tck_s, r_tck_d, r_tms_m, r_tms_s, r_tdi_m, r_tdi_s} <= '0;
        end else begin
            {r_tck_m, r_tck_s, r_tck_d} <= {tck_in, r_tck_m, r_tck_s};
            {r_tms_m, r_tms_s} <= {tms_in, r_tms_m};
            {r_tdi_m, r_tdi_s} <= {tdi_in, r_tdi_m};
        end
    end

    // TAP state register
    always_ff @(posedge bus_clk) begin
        r_state <= bus_reset ? TLR : w_next;
    end

    // TMS transition table, evaluated only on a TCK rise
    always_comb begin
        w_next = r_state;
        if (w_rise) begin
            case (r_state)
                TLR:     w_next = r_tms_s ? TLR    : RTI;
                RTI:     w_next = r_tms_s ? SEL_DR : RTI;
                SEL_DR:  w_next = r_tms_s ? SEL_IR : CAP_DR;
                CAP_DR:  w_next = r_tms_s ? EX1_DR : SH_DR;
                SH_DR:   w_next = r_tms_s ? EX1_DR : SH_DR;
                EX1_DR:  w_next = r_tms_s ? UPD_DR : PAU_DR;
                PAU_DR:  w_next = r_tms_s ? EX2_DR : PAU_DR;
                EX2_DR:  w_next = r_tms_s ? UPD_DR : SH_DR;
                UPD_DR:  w_next = r_tms_s ? SEL_DR : RTI;
                SEL_IR:  w_next = r_tms_s ? TLR    : CAP_IR;
                CAP_IR:  w_next = r_tms_s ? EX1_IR : SH_IR;
                SH_IR:   w_next = r_tms_s ? EX1_IR : SH_IR;
                EX1_IR:  w_next = r_tms_s ? UPD_IR : PAU_IR;
                PAU_IR:  w_next = r_tms_s ? EX2_IR : PAU_IR;
                EX2_IR:  w_next = r_tms_s ? UPD_IR : SH_IR;
                UPD_IR:  w_next = r_tms_s ? SEL_DR : RTI;
                default: w_next = TLR;
            endcase
        end
    end

    // capture and shift of the IR and DR shifters on TCK rise
    always_ff @(posedge bus_clk) begin
        if (bus_reset) begin
            r_ir_sr   <= '0;
            r_id_sr   <= '0;
            r_user_sr <= '0;
            r_byp     <= 1'b0;
        end else if (w_rise) begin
            if (r_state == CAP_IR) r_ir_sr <= IR_WIDTH'(1);
            if (r_state == SH_IR) r_ir_sr <= {r_tdi_s, r_ir_sr[IR_WIDTH-1:1]};
            if (r_state == CAP_DR) begin
                if (w_sel_id) r_id_sr <= IDCODE_VAL;
                else if (w_sel_user) r_user_sr <= user_capture_data;
                else r_byp <= 1'b0;
            end
            if (r_state == SH_DR) begin
                if (w_sel_id) r_id_sr <= {r_tdi_s, r_id_sr[31:1]};
                else if (w_sel_user) r_user_sr <= (r_user_sr >> 1) | (USER_WIDTH'(r_tdi_s) << (USER_WIDTH - 1));
                else r_byp <= r_tdi_s;
            end
        end
    end

    // instruction/user updates and TDO launch on TCK fall
    always_ff @(posedge bus_clk) begin
        if (bus_reset) begin
            r_ir       <= IR_WIDTH'(1);
            r_user_upd <= '0;
            r_strobe   <= 1'b0;
            r_tdo      <= 1'b0;
            r_oe       <= 1'b0;
        end else begin
            r_strobe <= w_fall && r_state == UPD_DR && w_sel_user;
            if (w_fall) begin
                if (r_state == TLR) r_ir <= IR_WIDTH'(1);
                else if (r_state == UPD_IR) r_ir <= r_ir_sr;
                if (r_state == UPD_DR && w_sel_user) r_user_upd <= r_user_sr;
                r_tdo <= r_state == SH_IR ? r_ir_sr[0] : r_state == SH_DR ? w_dr_lsb : 1'b0;
                r_oe  <= r_state == SH_IR || r_state == SH_DR;
            end
        end
    end

    assign tdo_out            = r_tdo;
    assign tdo_oe             = r_oe;
    assign user_update_data   = r_user_upd;
    assign user_update_strobe = r_strobe;
    assign tap_state          = r_state;
    assign test_logic_reset   = r_state == TLR;
endmodule

// File: tb/tb_jtag_tap_slave.sv
// tb_jtag_tap_slave: directed bit-banged JTAG sequences against jtag_tap_slave
module tb_jtag_tap_slave;
    logic        bus_clk, bus_reset, tck_in, tms_in, tdi_in;
    logic        tdo_out, tdo_oe, user_update_strobe, test_logic_reset;
    logic [31:0] user_capture_data, user_update_data;
    logic [3:0]  tap_state;
    int          n_tests, n_fail, strobe_cnt, s0, oe_bad;
    logic [31:0] d;

    jtag_tap_slave dut (
        .bus_clk(bus_clk), .bus_reset(bus_reset), .tck_in(tck_in), .tms_in(tms_in),
        .tdi_in(tdi_in), .tdo_out(tdo_out), .tdo_oe(tdo_oe),
        .user_capture_data(user_capture_data), .user_update_data(user_update_data),
        .user_update_strobe(user_update_strobe), .tap_state(tap_state),
        .test_logic_reset(test_logic_reset)
    );

    initial bus_clk = 1'b0;
    always #5 bus_clk = ~bus_clk;

    // strobe high-cycle counter, sampled away from the active edge
    initial strobe_cnt = 0;
    always @(negedge bus_clk) if (user_update_strobe) strobe_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tck_step(input logic tms, input logic tdi);
        tms_in = tms;
        tdi_in = tdi;
        repeat (4) @(negedge bus_clk);
        tck_in = 1'b1;
        repeat (5) @(negedge bus_clk);
        tck_in = 1'b0;
        repeat (5) @(negedge bus_clk);
    endtask

    task automatic move(input logic [7:0] seq, input int n);
        for (int i = 0; i < n; i++) tck_step(seq[i], 1'b0);
    endtask

    task automatic scan(input logic [31:0] din, input int n, output logic [31:0] dout, output int bad);
        dout = '0;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            dout[i] = tdo_out;
            if (tdo_oe !== 1'b1) bad++;
            tck_step(i == n - 1, din[i]);
        end
    endtask

    task automatic ir_load(input logic [3:0] code, output logic [31:0] cap);
        int b;
        move(8'b0011, 4);
        scan({28'd0, code}, 4, cap, b);
        move(8'b01, 2);
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        bus_reset = 1'b1;
        tck_in = 1'b0;
        tms_in = 1'b1;
        tdi_in = 1'b0;
        user_capture_data = 32'hCAFE_F00D;
        repeat (3) @(negedge bus_clk);
        bus_reset = 1'b0;
        @(negedge bus_clk);
        chk("rst_state", tap_state, 4'hF);
        chk("rst_oe", tdo_oe, 1'b0);
        chk("rst_tdo", tdo_out, 1'b0);
        chk("rst_ir", dut.r_ir, 4'h1);
        chk("rst_tlr", test_logic_reset, 1'b1);
        repeat (6) tck_step(1'b1, 1'b0);
        chk("tlr_hold", tap_state, 4'hF);

        move(8'b0010, 4);
        chk("id_shdr", tap_state, 4'h2);
        chk("id_oe_on", tdo_oe, 1'b1);
        scan(32'h0, 32, d, oe_bad);
        chk("id_value", d, 32'h1000_0001);
        chk("id_oe_during", oe_bad, 0);
        chk("id_ex1", tap_state, 4'h1);
        chk("id_oe_off", tdo_oe, 1'b0);
        move(8'b01, 2);
        chk("id_rti", tap_state, 4'hC);

        ir_load(4'hF, d);
        chk("ir_capture", d, 32'h1);
        chk("ir_bypass", dut.r_ir, 4'hF);
        move(8'b001, 3);
        scan(32'b01101, 5, d, oe_bad);
        chk("byp_delay", d, 32'b11010);
        move(8'b01, 2);

        ir_load(4'h2, d);
        chk("ir_user", dut.r_ir, 4'h2);
        move(8'b001, 3);
        scan(32'h1234_5678, 32, d, oe_bad);
        chk("user_capture", d, 32'hCAFE_F00D);
        s0 = strobe_cnt;
        tck_step(1'b1, 1'b0);
        chk("user_upd_state", tap_state, 4'h5);
        chk("user_update", user_update_data, 32'h1234_5678);
        chk("user_strobe_one", strobe_cnt - s0, 1);
        tck_step(1'b0, 1'b0);

        ir_load(4'h3, d);
        move(8'b001, 3);
        scan(32'b101, 3, d, oe_bad);
        tck_step(1'b0, 1'b0);
        chk("pause_state", tap_state, 4'h3);
        s0 = strobe_cnt;
        repeat (5) tck_step(1'b1, 1'b0);
        chk("esc_state", tap_state, 4'hF);
        chk("esc_ir", dut.r_ir, 4'h1);
        chk("esc_no_strobe", strobe_cnt - s0, 0);
        chk("esc_user_kept", user_update_data, 32'h1234_5678);

        move(8'b0010, 4);
        repeat (10) tck_step(1'b0, 1'b1);
        chk("mid_oe", tdo_oe, 1'b1);
        bus_reset = 1'b1;
        @(negedge bus_clk);
        bus_reset = 1'b0;
        chk("mrst_state", tap_state, 4'hF);
        chk("mrst_oe", tdo_oe, 1'b0);
        chk("mrst_tdo", tdo_out, 1'b0);
        chk("mrst_id_sr", dut.r_id_sr, 32'h0);
        chk("mrst_user_sr", dut.r_user_sr, 32'h0);
        chk("mrst_ir_sr", dut.r_ir_sr, 4'h0);
        chk("mrst_user_upd", user_update_data, 32'h0);
        repeat (3) @(negedge bus_clk);
        move(8'b0010, 4);
        scan(32'h0, 32, d, oe_bad);
        chk("id_after_rst", d, 32'h1000_0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
